// File: rtl/ysyx_23060236_ifu_fetch_pkg.sv
// Shared widths and reset vector for the instruction-fetch path.
package ysyx_23060236_ifu_fetch_pkg;

    localparam int ADDR_LEN = 32;
    localparam int DATA_LEN = 32;

    // Boot address of the core.
    localparam logic [ADDR_LEN-1:0] RESET_PC = 32'h3000_0000;

    // Read response code for a clean transfer; anything else is a fault.
    localparam logic [1:0] RESP_OKAY = 2'b00;

    // Instructions are word aligned, so the low two address bits are always zero.
    function automatic logic [ADDR_LEN-1:0] word_align(input logic [ADDR_LEN-1:0] addr);
        return {addr[ADDR_LEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/ysyx_23060236_ifu_fetch.sv
// Instruction fetch unit: issues one read per instruction, waits for the
// response, hands it to the decoder, and follows BTB predictions and EXU
// redirects. Responses belonging to a request that was overtaken by a
// redirect are drained and dropped.
module ysyx_23060236_ifu_fetch
    import ysyx_23060236_ifu_fetch_pkg::ADDR_LEN,
           ysyx_23060236_ifu_fetch_pkg::DATA_LEN,
           ysyx_23060236_ifu_fetch_pkg::RESP_OKAY,
           ysyx_23060236_ifu_fetch_pkg::word_align;
#(
    parameter logic [ADDR_LEN-1:0] RESET_PC = ysyx_23060236_ifu_fetch_pkg::RESET_PC
) (
    input  logic                clock,
    input  logic                reset,

    output logic [ADDR_LEN-1:0] btb_araddr,
    input  logic [ADDR_LEN-1:0] btb_rdata,

    output logic                ifu_arvalid,
    output logic [ADDR_LEN-1:0] ifu_araddr,
    input  logic                ifu_arready,

    input  logic                ifu_rvalid,
    input  logic [DATA_LEN-1:0] ifu_rdata,
    input  logic [1:0]          ifu_rresp,
    output logic                ifu_rready,

    output logic                inst_valid,
    input  logic                inst_ready,
    output logic [DATA_LEN-1:0] inst,
    output logic [ADDR_LEN-1:0] inst_pc,
    output logic [ADDR_LEN-1:0] inst_pred_pc,
    output logic                inst_fault,

    input  logic                redirect_valid,
    input  logic [ADDR_LEN-1:0] redirect_pc
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_DRAIN
    } state_e;

    state_e              state_q,    state_d;
    logic [ADDR_LEN-1:0] pc_q,       pc_d;
    logic [ADDR_LEN-1:0] pred_pc_q,  pred_pc_d;
    logic [ADDR_LEN-1:0] araddr_q,   araddr_d;    // address of a request held across cycles
    logic [ADDR_LEN-1:0] fetch_pc_q, fetch_pc_d;  // address of the accepted request
    logic [DATA_LEN-1:0] inst_q,     inst_d;
    logic                fault_q,    fault_d;
    logic                flush_q,    flush_d;     // outstanding request is stale
    logic                first_q,    first_d;     // arvalid is being raised this cycle

    logic [ADDR_LEN-1:0] redir_pc;
    logic [ADDR_LEN-1:0] req_addr;
    logic                ar_fire;

    assign redir_pc = word_align(redirect_pc);
    // On the first request cycle the address comes straight from pc; after
    // that it is frozen in araddr_q so a redirect cannot disturb it.
    assign req_addr = first_q ? pc_q : araddr_q;
    assign ar_fire  = (state_q == S_REQ) && ifu_arready;

    assign btb_araddr   = pc_q;
    assign ifu_arvalid  = (state_q == S_REQ);
    assign ifu_araddr   = (state_q == S_REQ) ? req_addr : '0;
    assign ifu_rready   = (state_q == S_WAIT) || (state_q == S_DRAIN);
    // A redirect kills the held instruction in the same cycle.
    assign inst_valid   = (state_q == S_HOLD) && !redirect_valid;
    assign inst         = inst_q;
    assign inst_pc      = fetch_pc_q;
    assign inst_pred_pc = pred_pc_q;
    assign inst_fault   = fault_q;

    // Next-state and datapath updates for the fetch sequence.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pred_pc_d  = pred_pc_q;
        araddr_d   = araddr_q;
        fetch_pc_d = fetch_pc_q;
        inst_d     = inst_q;
        fault_d    = fault_q;
        flush_d    = flush_q;
        first_d    = first_q;

        unique case (state_q)
            S_IDLE: begin
                state_d = S_REQ;
                first_d = 1'b1;
                flush_d = 1'b0;
            end

            S_REQ: begin
                first_d  = 1'b0;
                araddr_d = req_addr;
                if (ar_fire) begin
                    fetch_pc_d = req_addr;
                    pred_pc_d  = btb_rdata;
                    if (redirect_valid || flush_q) begin
                        // The response will be for a dead path: swallow it.
                        if (redirect_valid) begin
                            pc_d = redir_pc;
                        end
                        flush_d = 1'b0;
                        state_d = S_DRAIN;
                    end else begin
                        state_d = S_WAIT;
                    end
                end else if (redirect_valid) begin
                    pc_d = redir_pc;
                    if (first_q) begin
                        // Request only just raised: retarget it.
                        araddr_d = redir_pc;
                    end else begin
                        // Address already committed: finish it, then drop it.
                        flush_d = 1'b1;
                    end
                end
            end

            S_WAIT: begin
                if (redirect_valid) begin
                    pc_d = redir_pc;
                    if (ifu_rvalid) begin
                        state_d = S_REQ;
                        first_d = 1'b1;
                    end else begin
                        state_d = S_DRAIN;
                    end
                end else if (ifu_rvalid) begin
                    inst_d  = ifu_rdata;
                    fault_d = (ifu_rresp != RESP_OKAY);
                    state_d = S_HOLD;
                end
            end

            S_HOLD: begin
                if (redirect_valid) begin
                    pc_d    = redir_pc;
                    state_d = S_REQ;
                    first_d = 1'b1;
                end else if (inst_ready) begin
                    pc_d    = word_align(pred_pc_q);
                    state_d = S_REQ;
                    first_d = 1'b1;
                end
            end

            S_DRAIN: begin
                if (redirect_valid) begin
                    pc_d = redir_pc;
                end
                if (ifu_rvalid) begin
                    state_d = S_REQ;
                    first_d = 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            pred_pc_q  <= '0;
            araddr_q   <= '0;
            fetch_pc_q <= '0;
            inst_q     <= '0;
            fault_q    <= 1'b0;
            flush_q    <= 1'b0;
            first_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pred_pc_q  <= pred_pc_d;
            araddr_q   <= araddr_d;
            fetch_pc_q <= fetch_pc_d;
            inst_q     <= inst_d;
            fault_q    <= fault_d;
            flush_q    <= flush_d;
            first_q    <= first_d;
        end
    end

endmodule

// File: tb/tb_ysyx_23060236_ifu_fetch.sv
// Directed scenarios followed by a randomized run against a transaction-level
// model of the fetch stream (memory, BTB and redirect rules).
module tb_ysyx_23060236_ifu_fetch;

    logic        clk;
    logic        rst_n;
    logic [31:0] btb_araddr;
    logic [31:0] btb_rdata;
    logic        ifu_arvalid;
    logic [31:0] ifu_araddr;
    logic        ifu_arready;
    logic        ifu_rvalid;
    logic [31:0] ifu_rdata;
    logic [1:0]  ifu_rresp;
    logic        ifu_rready;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic [31:0] inst_pred_pc;
    logic        inst_fault;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    int n_checks = 0;
    int n_errors = 0;

    ysyx_23060236_ifu_fetch dut (
        .clock          (clk),
        .reset          (rst_n),
        .btb_araddr     (btb_araddr),
        .btb_rdata      (btb_rdata),
        .ifu_arvalid    (ifu_arvalid),
        .ifu_araddr     (ifu_araddr),
        .ifu_arready    (ifu_arready),
        .ifu_rvalid     (ifu_rvalid),
        .ifu_rdata      (ifu_rdata),
        .ifu_rresp      (ifu_rresp),
        .ifu_rready     (ifu_rready),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .inst_pred_pc   (inst_pred_pc),
        .inst_fault     (inst_fault),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference memory contents, fault map and BTB behaviour.
    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9bdf;
    endfunction

    function automatic logic fault_fn(input logic [31:0] a);
        return a[6:2] == 5'd19;
    endfunction

    function automatic logic [31:0] btb_fn(input logic [31:0] a);
        logic [31:0] t;
        t = a + 32'd4;
        if (a[5:2] == 4'd9) t = {a[31:12], ~a[11:2], 2'b00};
        return t;
    endfunction

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        btb_rdata      = '0;
        ifu_arready    = 1'b0;
        ifu_rvalid     = 1'b0;
        ifu_rdata      = '0;
        ifu_rresp      = 2'b00;
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
    endtask

    // One zero-wait fetch starting in the request state: 3 cycles per instruction.
    task automatic fetch_one(input string tag, input logic [31:0] addr, input logic [31:0] btb_next,
                             input logic [31:0] data, input logic [1:0] resp);
        check_eq({tag, "_arvalid"}, ifu_arvalid, 1'b1);
        check_eq({tag, "_araddr"}, ifu_araddr, addr);
        ifu_arready = 1'b1;
        btb_rdata   = btb_next;
        cyc();
        ifu_arready = 1'b0;
        ifu_rvalid  = 1'b1;
        ifu_rdata   = data;
        ifu_rresp   = resp;
        #1;
        check_eq({tag, "_rready"}, ifu_rready, 1'b1);
        cyc();
        ifu_rvalid = 1'b0;
        inst_ready = 1'b1;
        #1;
        check_eq({tag, "_inst_valid"}, inst_valid, 1'b1);
        check_eq({tag, "_inst"}, inst, data);
        check_eq({tag, "_inst_pc"}, inst_pc, addr);
        check_eq({tag, "_pred_pc"}, inst_pred_pc, btb_next);
        check_eq({tag, "_fault"}, inst_fault, resp != 2'b00);
        $display("fetch %s pc=%h inst=%h pred=%h fault=%0d", tag, inst_pc, inst, inst_pred_pc, inst_fault);
        cyc();
        inst_ready = 1'b0;
        #1;
    endtask

    initial begin
        logic [31:0] exp_pc, s_addr, prev_addr;
        logic        busy, prev_pending, prev_fresh, prev_redir;
        logic        ar_fire, r_fire, i_fire;
        int          lat, idle, n_deliv;

        rst_n = 1'b0;
        clear_inputs();
        repeat (2) @(negedge clk);

        // Reset state: everything low except the BTB lookup address.
        check_eq("rst_arvalid", ifu_arvalid, 1'b0);
        check_eq("rst_araddr", ifu_araddr, 32'h0);
        check_eq("rst_rready", ifu_rready, 1'b0);
        check_eq("rst_inst_valid", inst_valid, 1'b0);
        check_eq("rst_btb_araddr", btb_araddr, 32'h3000_0000);
        check_eq("rst_inst", inst, 32'h0);
        check_eq("rst_pred_pc", inst_pred_pc, 32'h0);
        check_eq("rst_fault", inst_fault, 1'b0);

        // Release: idle for one cycle, then the first request appears.
        rst_n = 1'b1;
        #1;
        check_eq("idle_arvalid", ifu_arvalid, 1'b0);
        cyc();

        // Straight-line fetches, BTB miss then BTB hit.
        fetch_one("boot", 32'h3000_0000, 32'h3000_0004, 32'h0000_0013, 2'b00);
        fetch_one("seq", 32'h3000_0004, 32'h3000_0008, 32'h0010_0093, 2'b00);
        fetch_one("btb_hit", 32'h3000_0008, 32'h3000_0100, 32'h0040_006f, 2'b00);

        // Redirect while waiting for data; response arrives 2 cycles later.
        check_eq("wait_redir_araddr", ifu_araddr, 32'h3000_0100);
        ifu_arready = 1'b1;
        btb_rdata   = 32'h3000_0104;
        cyc();
        ifu_arready    = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h3000_0203;
        #1;
        check_eq("wait_redir_rready", ifu_rready, 1'b1);
        check_eq("wait_redir_valid0", inst_valid, 1'b0);
        cyc();
        redirect_valid = 1'b0;
        #1;
        check_eq("drain_rready", ifu_rready, 1'b1);
        check_eq("drain_valid1", inst_valid, 1'b0);
        cyc();
        ifu_rvalid = 1'b1;
        ifu_rdata  = 32'hdead_beef;
        #1;
        check_eq("drain_valid2", inst_valid, 1'b0);
        cyc();
        ifu_rvalid = 1'b0;
        #1;
        check_eq("drain_valid3", inst_valid, 1'b0);
        check_eq("drain_next_araddr", ifu_araddr, 32'h3000_0200);
        $display("redirect in wait -> refetch %h", ifu_araddr);

        // arready low 4 cycles, redirect on the second: address held, then drained.
        for (int i = 0; i < 4; i++) begin
            redirect_valid = (i == 1);
            redirect_pc    = 32'h3000_0400;
            #1;
            check_eq("stall_arvalid", ifu_arvalid, 1'b1);
            check_eq("stall_araddr", ifu_araddr, 32'h3000_0200);
            cyc();
        end
        redirect_valid = 1'b0;
        ifu_arready    = 1'b1;
        btb_rdata      = 32'h3000_0204;
        #1;
        check_eq("stall_hs_araddr", ifu_araddr, 32'h3000_0200);
        cyc();
        ifu_arready = 1'b0;
        ifu_rvalid  = 1'b1;
        ifu_rdata   = 32'h1234_5678;
        #1;
        check_eq("stall_drain_rready", ifu_rready, 1'b1);
        check_eq("stall_drain_valid", inst_valid, 1'b0);
        cyc();
        ifu_rvalid = 1'b0;
        #1;
        check_eq("stall_next_araddr", ifu_araddr, 32'h3000_0400);
        $display("redirect in stalled request -> refetch %h", ifu_araddr);

        // Held instruction, then redirect and inst_ready together.
        ifu_arready = 1'b1;
        btb_rdata   = 32'h3000_0404;
        cyc();
        ifu_arready = 1'b0;
        ifu_rvalid  = 1'b1;
        ifu_rdata   = 32'hcafe_0013;
        cyc();
        ifu_rvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            check_eq("hold_valid", inst_valid, 1'b1);
            cyc();
        end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h3000_0800;
        inst_ready     = 1'b1;
        #1;
        check_eq("hold_redir_valid", inst_valid, 1'b0);
        cyc();
        redirect_valid = 1'b0;
        inst_ready     = 1'b0;
        #1;
        check_eq("hold_redir_araddr", ifu_araddr, 32'h3000_0800);
        $display("redirect in hold -> refetch %h", ifu_araddr);

        // Faulting response is still delivered.
        fetch_one("fault", 32'h3000_0800, 32'h3000_0804, 32'h0000_0073, 2'b10);

        // Asynchronous reset in the middle of a wait.
        ifu_arready = 1'b1;
        btb_rdata   = 32'h3000_0808;
        cyc();
        ifu_arready = 1'b0;
        #1;
        check_eq("pre_rst_rready", ifu_rready, 1'b1);
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("async_rst_arvalid", ifu_arvalid, 1'b0);
        check_eq("async_rst_rready", ifu_rready, 1'b0);
        check_eq("async_rst_valid", inst_valid, 1'b0);
        check_eq("async_rst_pc", btb_araddr, 32'h3000_0000);
        $display("async reset mid-wait");
        @(negedge clk);
        clear_inputs();
        rst_n = 1'b1;

        // Randomized run against the stream model.
        exp_pc       = 32'h3000_0000;
        busy         = 1'b0;
        s_addr       = '0;
        lat          = 0;
        prev_pending = 1'b0;
        prev_fresh   = 1'b0;
        prev_redir   = 1'b0;
        prev_addr    = '0;
        idle         = 0;
        n_deliv      = 0;
        for (int cyc_i = 0; cyc_i < 3000; cyc_i++) begin
            ifu_arready    = ($urandom_range(0, 99) < 60);
            inst_ready     = ($urandom_range(0, 99) < 70);
            redirect_valid = (cyc_i >= 2) && ($urandom_range(0, 99) < 8);
            redirect_pc    = 32'h3000_0000 | $urandom_range(0, 32'h0fff);
            btb_rdata      = btb_fn(btb_araddr);
            if (busy && lat == 0) begin
                ifu_rvalid = 1'b1;
                ifu_rdata  = mem_fn(s_addr);
                ifu_rresp  = fault_fn(s_addr) ? 2'b10 : 2'b00;
            end else begin
                ifu_rvalid = 1'b0;
                ifu_rdata  = $urandom;
                ifu_rresp  = 2'b00;
            end
            #1;
            ar_fire = ifu_arvalid && ifu_arready;
            r_fire  = ifu_rvalid && ifu_rready;
            i_fire  = inst_valid && inst_ready;

            // A pending request may only move if it was retargeted on its first cycle.
            if (prev_pending && !(prev_redir && prev_fresh)) begin
                check_eq("ar_hold_valid", ifu_arvalid, 1'b1);
                check_eq("ar_hold_addr", ifu_araddr, prev_addr);
            end
            if (redirect_valid) check_eq("redirect_gates_valid", inst_valid, 1'b0);

            if (i_fire) begin
                check_eq("rnd_inst_pc", inst_pc, exp_pc);
                check_eq("rnd_inst", inst, mem_fn(exp_pc));
                check_eq("rnd_fault", inst_fault, fault_fn(exp_pc));
                check_eq("rnd_pred_pc", inst_pred_pc, btb_fn(exp_pc));
                $display("fetch rnd pc=%h inst=%h pred=%h fault=%0d", inst_pc, inst, inst_pred_pc, inst_fault);
                exp_pc = btb_fn(exp_pc);
                n_deliv++;
                idle = 0;
            end else begin
                idle++;
            end
            if (redirect_valid) exp_pc = redirect_pc & ~32'h3;

            if (r_fire) busy = 1'b0;
            else if (busy && lat > 0) lat--;
            if (ar_fire) begin
                check_eq("ar_single_outstanding", busy, 1'b0);
                busy   = 1'b1;
                s_addr = ifu_araddr;
                lat    = $urandom_range(0, 3);
            end

            prev_fresh   = ifu_arvalid && !prev_pending;
            prev_pending = ifu_arvalid && !ifu_arready;
            prev_addr    = ifu_araddr;
            prev_redir   = redirect_valid;

            if (idle > 400) begin
                check_eq("fetch_progress_cycles", idle, 400);
                break;
            end
            cyc();
        end
        check_eq("rnd_deliveries_min", n_deliv >= 50, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ysyx_23060236_ifu_fetch.md
YSYX_23060236_IFU_FETCH -- requirements
Module: ysyx_23060236_ifu_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h3000_0000, giving the first fetch address after reset.
REQ-002 SHALL have port clock  in  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  in  1  reset, asynchronous and active-low.
REQ-004 SHALL have port btb_araddr  out  32  current PC, presented to the BTB lookup port.
REQ-005 SHALL have port btb_rdata  in  32  predicted next PC returned by the BTB for btb_araddr.
REQ-006 SHALL have ports ifu_arvalid out 1, ifu_araddr out 32, ifu_arready in 1  instruction-memory read-address channel.
REQ-007 SHALL have ports ifu_rvalid in 1, ifu_rdata in 32, ifu_rresp in 2, ifu_rready out 1  instruction-memory read-data channel.
REQ-008 SHALL have ports inst_valid out 1, inst_ready in 1, inst out 32, inst_pc out 32, inst_pred_pc out 32, inst_fault out 1  instruction handoff to IDU.
REQ-009 SHALL have ports redirect_valid in 1, redirect_pc in 32  EXU mispredict/trap redirect.

Function
REQ-010 SHALL implement states S_IDLE, S_REQ, S_WAIT, S_HOLD, S_DRAIN.
REQ-011 S_IDLE: all handshake outputs low; unconditional move to S_REQ next cycle.
REQ-012 S_REQ: ifu_arvalid=1, ifu_araddr=pc; on arvalid&arready, latch pred_pc<=btb_rdata and go to S_WAIT.
REQ-013 ifu_araddr and ifu_arvalid SHALL stay stable from assertion until arready; redirect never changes ifu_araddr mid-request.
REQ-014 Redirect in S_REQ without handshake: pc<=redirect_pc, stay S_REQ only if arvalid was first asserted this cycle; otherwise set flush flag, keep address, and on handshake go to S_DRAIN.
REQ-015 S_WAIT: ifu_rready=1; on rvalid capture inst<=rdata, inst_fault<=(rresp!=0), go to S_HOLD.
REQ-016 Redirect in S_WAIT without rvalid: pc<=redirect_pc, go to S_DRAIN; with rvalid same cycle: discard data, pc<=redirect_pc, go to S_REQ.
REQ-017 S_HOLD: inst_valid=1; on inst_ready, pc<=pred_pc and go to S_REQ.
REQ-018 Redirect in S_HOLD takes priority over inst_ready: inst_valid gated low that cycle, pc<=redirect_pc, go to S_REQ.
REQ-019 S_DRAIN: ifu_rready=1, inst_valid=0; on rvalid discard data, go to S_REQ; a further redirect overwrites pc.
REQ-020 btb_araddr SHALL equal pc combinationally in every state.
REQ-021 inst_pc SHALL equal the address fetched; inst_pred_pc SHALL equal pred_pc latched for that fetch.
REQ-022 redirect_pc[1:0] SHALL be ignored and pc[1:0] forced to 2'b00.
REQ-023 Minimum fetch throughput SHALL be one instruction per 3 cycles with zero-wait memory and inst_ready=1.
REQ-024 A faulting response SHALL still be delivered via S_HOLD with inst_fault=1; next pc is pred_pc.

Reset
REQ-025 While reset=0: state=S_IDLE, pc=RESET_PC, pred_pc=0, flush flag=0, inst=0, inst_fault=0.
REQ-026 Reset SHALL take effect asynchronously; all outputs low (btb_araddr=RESET_PC) during reset, including mid-transaction.
REQ-027 After reset release, ifu_arvalid SHALL assert on the second rising edge with ifu_araddr=RESET_PC.

Structure
REQ-028 ADDR_LEN, DATA_LEN, RESET_PC SHALL live in the shared defines file; state encodings stay local.
REQ-029 No sub-module; BTB is instantiated beside this block at CPU top, not inside it.

Verification
REQ-030 Reset release, arready=1, rvalid 1 cycle later with rdata=32'h00000013, BTB miss -> araddr 3000_0000, inst_pc 3000_0000, inst_pred_pc 3000_0004, next araddr 3000_0004.
REQ-031 BTB returns 3000_0100 for pc 3000_0008 -> after accept, next ifu_araddr=3000_0100.
REQ-032 Redirect to 3000_0203 while in S_WAIT, rvalid 2 cycles later -> data discarded, inst_valid never high, next araddr 3000_0200.
REQ-033 arready held low 4 cycles, redirect on cycle 2 -> araddr unchanged until handshake, response drained, then fetch from redirect target.
REQ-034 S_HOLD with inst_ready=0 for 5 cycles, then redirect and inst_ready same cycle -> inst_valid low that cycle, next araddr=redirect_pc.
REQ-035 rresp=2'b10 -> inst_fault=1 with inst_valid; reset asserted mid-S_WAIT -> arvalid/rready/inst_valid drop immediately, pc=3000_0000.
